// File: rtl/acorn_128_if.sv
`timescale 1ns/1ps
`default_nettype none
// acorn_128_if: request/result bundle between a host (master) and the ACORN-128 core (slave).
interface acorn_128_if;
  logic         start_in;
  logic         encrypt_in;
  logic [127:0] key_in;
  logic [127:0] iv_in;
  logic [127:0] plaintext_in;
  logic [127:0] ciphertext_in;
  logic [127:0] associated_data_in;
  logic [63:0]  data_length_in;
  logic [127:0] ciphertext_out;
  logic [127:0] plaintext_out;
  logic [127:0] tag_out;
  logic         ready_out;

  modport master (
    output start_in, encrypt_in, key_in, iv_in, plaintext_in, ciphertext_in,
           associated_data_in, data_length_in,
    input  ciphertext_out, plaintext_out, tag_out, ready_out
  );

  modport slave (
    input  start_in, encrypt_in, key_in, iv_in, plaintext_in, ciphertext_in,
           associated_data_in, data_length_in,
    output ciphertext_out, plaintext_out, tag_out, ready_out
  );
endinterface
`default_nettype wire

// File: rtl/acorn_128_top.sv
`timescale 1ns/1ps
`default_nettype none
// acorn_128_top: single-block ACORN-128 v3 encrypt/decrypt core, one state step per clock.
// Define ACORN_PAR8_EN to unroll eight steps per clock (416 cycles instead of 3328).
module acorn_128_top (
  input wire         clk,
  input wire         rst,
  acorn_128_if.slave bus
);
`ifdef ACORN_PAR8_EN
  localparam int unsigned STEPS      = 8;
  localparam int unsigned LOG2_STEPS = 3;
`else
  localparam int unsigned STEPS      = 1;
  localparam int unsigned LOG2_STEPS = 0;
`endif
  localparam logic [10:0] INIT_LEN  = 11'(1792 / STEPS);
  localparam logic [10:0] BLK_LEN   = 11'(128 / STEPS);
  localparam logic [10:0] PAD_LEN   = 11'(256 / STEPS);
  localparam logic [10:0] FINAL_LEN = 11'(768 / STEPS);
  localparam logic [10:0] TAG_FIRST = 11'd640;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_AD, ST_AD_PAD, ST_MSG, ST_MSG_PAD, ST_FINAL, ST_DONE
  } state_e;

  state_e           state_q;
  logic [10:0]      cnt_q;
  logic [292:0]     s_q, s_d;
  logic             enc_q, ready_q;
  logic [127:0]     ct_q, pt_q, tag_q;
  logic [STEPS-1:0] ks_d, res_d;
  logic [10:0]      base, idx, last_cnt;
  logic             m, ca, cb, ks, f;
  logic             unused_len;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

  assign unused_len = ^bus.data_length_in;
  assign base       = cnt_q << LOG2_STEPS;

  always_comb begin
    last_cnt = '0;
    case (state_q)
      ST_INIT:               last_cnt = INIT_LEN - 11'd1;
      ST_AD, ST_MSG:         last_cnt = BLK_LEN - 11'd1;
      ST_AD_PAD, ST_MSG_PAD: last_cnt = PAD_LEN - 11'd1;
      ST_FINAL:              last_cnt = FINAL_LEN - 11'd1;
      default:               last_cnt = '0;
    endcase
  end

  always_comb begin
    s_d   = s_q;
    ks_d  = '0;
    res_d = '0;
    idx   = '0;
    m     = 1'b0;
    ca    = 1'b1;
    cb    = 1'b1;
    ks    = 1'b0;
    f     = 1'b0;
    for (int unsigned k = 0; k < STEPS; k++) begin
      idx = base + 11'(k);
      m   = 1'b0;
      ca  = 1'b1;
      cb  = 1'b1;
      case (state_q)
        ST_INIT: begin
          // Step 256 re-injects key bit 0 inverted as the domain separator.
          if (idx == 11'd256)
            m = ~bus.key_in[0];
          else if (idx >= 11'd128 && idx < 11'd256)
            m = bus.iv_in[idx[6:0]];
          else
            m = bus.key_in[idx[6:0]];
        end
        ST_AD:      m = bus.associated_data_in[idx[6:0]];
        ST_AD_PAD:  begin m = (idx == 11'd0); ca = (idx < 11'd128); end
        ST_MSG:     cb = 1'b0;
        ST_MSG_PAD: begin m = (idx == 11'd0); ca = (idx < 11'd128); cb = 1'b0; end
        default:    m = 1'b0;
      endcase
      s_d[289] = s_d[289] ^ s_d[235] ^ s_d[230];
      s_d[230] = s_d[230] ^ s_d[196] ^ s_d[193];
      s_d[193] = s_d[193] ^ s_d[160] ^ s_d[154];
      s_d[154] = s_d[154] ^ s_d[111] ^ s_d[107];
      s_d[107] = s_d[107] ^ s_d[66]  ^ s_d[61];
      s_d[61]  = s_d[61]  ^ s_d[23]  ^ s_d[0];
      ks = s_d[12] ^ s_d[154] ^ maj(s_d[235], s_d[61], s_d[193])
         ^ ch(s_d[230], s_d[111], s_d[66]);
      // The message stream always absorbs plaintext, so decrypt recovers it first.
      if (state_q == ST_MSG) begin
        m        = enc_q ? bus.plaintext_in[idx[6:0]] : (bus.ciphertext_in[idx[6:0]] ^ ks);
        res_d[k] = enc_q ? (m ^ ks) : m;
      end
      f = s_d[0] ^ ~s_d[107] ^ maj(s_d[244], s_d[23], s_d[160])
        ^ (ca & s_d[196]) ^ (cb & ks) ^ m;
      s_d     = {f, s_d[292:1]};
      ks_d[k] = ks;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      enc_q   <= 1'b0;
      ready_q <= 1'b0;
      ct_q    <= '0;
      pt_q    <= '0;
      tag_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start_in) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            s_q     <= '0;
            enc_q   <= bus.encrypt_in;
            ct_q    <= '0;
            pt_q    <= '0;
            tag_q   <= '0;
          end
        end
        ST_DONE: begin
          if (!ready_q) begin
            ready_q <= 1'b1;
          end else if (!bus.start_in) begin
            ready_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          s_q <= s_d;
          if (state_q == ST_MSG) begin
            if (enc_q) ct_q[base[6:0] +: STEPS] <= res_d;
            else       pt_q[base[6:0] +: STEPS] <= res_d;
          end
          if (state_q == ST_FINAL && base >= TAG_FIRST)
            tag_q[base[6:0] +: STEPS] <= ks_d;
          if (cnt_q == last_cnt) begin
            cnt_q   <= '0;
            state_q <= state_e'(state_q + 3'd1);
          end else begin
            cnt_q <= cnt_q + 11'd1;
          end
        end
      endcase
    end
  end

  assign bus.ciphertext_out = ct_q;
  assign bus.plaintext_out  = pt_q;
  assign bus.tag_out        = tag_q;
  assign bus.ready_out      = ready_q;
endmodule
`default_nettype wire

// File: tb/tb_acorn_128_top.sv
`timescale 1ns/1ps
`default_nettype none
// tb_acorn_128_top: randomized scoreboard bench comparing acorn_128_top with a bit-serial ACORN-128 model.
module tb_acorn_128_top;
`ifdef ACORN_PAR8_EN
  localparam int LATENCY  = 417;
  localparam int ABORT_AT = 200;
`else
  localparam int LATENCY  = 3329;
  localparam int ABORT_AT = 1000;
`endif
  localparam int TIMEOUT = LATENCY + 200;

  localparam logic [127:0] K_V  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] IV_V = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] AD_V = 128'h11223344556677889900AABBCCDDEEFF;
  localparam logic [127:0] PT_V = 128'hAABBCCDDEEFF00112233445566778899;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] pt;
    logic [127:0] tag;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  logic [292:0] rs;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  acorn_128_if u_if();
  acorn_128_top u_dut (.clk(clk), .rst(rst), .bus(u_if));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch3(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic ref_ks();
    rs[289] = rs[289] ^ rs[235] ^ rs[230];
    rs[230] = rs[230] ^ rs[196] ^ rs[193];
    rs[193] = rs[193] ^ rs[160] ^ rs[154];
    rs[154] = rs[154] ^ rs[111] ^ rs[107];
    rs[107] = rs[107] ^ rs[66]  ^ rs[61];
    rs[61]  = rs[61]  ^ rs[23]  ^ rs[0];
    return rs[12] ^ rs[154] ^ maj3(rs[235], rs[61], rs[193]) ^ ch3(rs[230], rs[111], rs[66]);
  endfunction

  function automatic void ref_shift(input logic m, input logic ca, input logic cb, input logic ks);
    logic f;
    f  = rs[0] ^ ~rs[107] ^ maj3(rs[244], rs[23], rs[160]) ^ (ca & rs[196]) ^ (cb & ks) ^ m;
    rs = {f, rs[292:1]};
  endfunction

  task automatic ref_model(input logic enc, input logic [127:0] key, input logic [127:0] iv,
                           input logic [127:0] ad, input logic [127:0] din, output exp_t e);
    logic ks, m, p;
    logic [127:0] c_acc, p_acc, t_acc;
    rs = '0;
    for (int i = 0; i < 1792; i++) begin
      if (i < 128)       m = key[i];
      else if (i < 256)  m = iv[i - 128];
      else if (i == 256) m = ~key[0];
      else               m = key[i % 128];
      ks = ref_ks();
      ref_shift(m, 1'b1, 1'b1, ks);
    end
    for (int i = 0; i < 128; i++) begin
      ks = ref_ks();
      ref_shift(ad[i], 1'b1, 1'b1, ks);
    end
    for (int i = 0; i < 256; i++) begin
      ks = ref_ks();
      ref_shift(i == 0, i < 128, 1'b1, ks);
    end
    for (int i = 0; i < 128; i++) begin
      ks = ref_ks();
      p  = enc ? din[i] : (din[i] ^ ks);
      c_acc[i] = p ^ ks;
      p_acc[i] = p;
      ref_shift(p, 1'b1, 1'b0, ks);
    end
    for (int i = 0; i < 256; i++) begin
      ks = ref_ks();
      ref_shift(i == 0, i < 128, 1'b0, ks);
    end
    for (int i = 0; i < 768; i++) begin
      ks = ref_ks();
      if (i >= 640) t_acc[i - 640] = ks;
      ref_shift(1'b0, 1'b1, 1'b1, ks);
    end
    e.ct  = enc ? c_acc : '0;
    e.pt  = enc ? '0 : p_acc;
    e.tag = t_acc;
    e.acc = 0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Issues one request; on acceptance the model's expected result goes to the scoreboard.
  task automatic start_op(input logic enc, input logic [127:0] key, input logic [127:0] iv,
                          input logic [127:0] ad, input logic [127:0] din, input bit track,
                          input bit hold, output exp_t e);
    @(negedge clk);
    u_if.start_in = 1'b0;
    repeat (2) @(negedge clk);
    u_if.encrypt_in         = enc;
    u_if.key_in             = key;
    u_if.iv_in              = iv;
    u_if.associated_data_in = ad;
    u_if.plaintext_in       = enc ? din : rnd128();
    u_if.ciphertext_in      = enc ? rnd128() : din;
    u_if.data_length_in     = {$urandom, $urandom};
    u_if.start_in           = 1'b1;
    @(posedge clk);
    #1;
    ref_model(enc, key, iv, ad, din, e);
    e.acc = cyc;
    if (track) sb_q.push_back(e);
    if (!hold) u_if.start_in = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (u_if.ready_out !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (u_if.ready_out !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: ready_out=%b expected 1 within %0d cycles", u_if.ready_out, n);
    end
  endtask

  initial begin : monitor
    logic prev_rdy;
    exp_t e;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (u_if.ready_out === 1'b1 && !prev_rdy) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: ready_out=1 expected 0 (no request pending)");
        end else begin
          e = sb_q.pop_front();
          check("ciphertext_out", u_if.ciphertext_out, e.ct);
          check("plaintext_out", u_if.plaintext_out, e.pt);
          check("tag_out", u_if.tag_out, e.tag);
          check("latency", 128'(cyc - e.acc), 128'(LATENCY));
        end
      end
      prev_rdy = (u_if.ready_out === 1'b1);
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t e, e_enc, e_tmp;
    int   abort_pts[2];
    logic [127:0] ad_f;
    abort_pts[0] = ABORT_AT;
    abort_pts[1] = LATENCY - 60;
    u_if.start_in           = 1'b0;
    u_if.encrypt_in         = 1'b0;
    u_if.key_in             = '0;
    u_if.iv_in              = '0;
    u_if.plaintext_in       = '0;
    u_if.ciphertext_in      = '0;
    u_if.associated_data_in = '0;
    u_if.data_length_in     = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", {127'b0, u_if.ready_out}, 128'd0);
    check("reset_ct", u_if.ciphertext_out, 128'd0);
    check("reset_pt", u_if.plaintext_out, 128'd0);
    check("reset_tag", u_if.tag_out, 128'd0);
    rst = 1'b1;

    start_op(1'b1, '0, '0, '0, '0, 1'b1, 1'b0, e);
    wait_ready();

    start_op(1'b1, K_V, IV_V, AD_V, PT_V, 1'b1, 1'b0, e_enc);
    wait_ready();

    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    start_op(1'b0, K_V, IV_V, AD_V, e_enc.ct, 1'b1, 1'b0, e);
    wait_ready();
    check("roundtrip_pt", u_if.plaintext_out, PT_V);
    check("roundtrip_tag", u_if.tag_out, e_enc.tag);

    ad_f = AD_V;
    ad_f[$urandom_range(0, 127)] ^= 1'b1;
    start_op(1'b1, K_V, IV_V, ad_f, PT_V, 1'b1, 1'b0, e);
    wait_ready();
    check("ad_flip_tag_differs", {127'b0, u_if.tag_out != e_enc.tag}, 128'd1);

    for (int a = 0; a < 2; a++) begin
      start_op(1'b1, rnd128(), rnd128(), rnd128(), rnd128(), 1'b0, 1'b0, e_tmp);
      repeat (abort_pts[a] - 1) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("abort_ready", {127'b0, u_if.ready_out}, 128'd0);
      check("abort_ct", u_if.ciphertext_out, 128'd0);
      check("abort_pt", u_if.plaintext_out, 128'd0);
      check("abort_tag", u_if.tag_out, 128'd0);
      @(negedge clk); rst = 1'b1;
      start_op(1'b1, K_V, IV_V, AD_V, PT_V, 1'b1, 1'b0, e);
      wait_ready();
    end

    start_op(1'b1, K_V, IV_V, AD_V, PT_V, 1'b1, 1'b1, e);
    wait_ready();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("hold_ready", {127'b0, u_if.ready_out}, 128'd1);
    end
    check("hold_ct", u_if.ciphertext_out, e_enc.ct);
    check("hold_tag", u_if.tag_out, e_enc.tag);
    u_if.start_in = 1'b0;
    @(posedge clk);
    #1;
    check("drop_ready", {127'b0, u_if.ready_out}, 128'd0);

    for (int r = 0; r < 4; r++) begin
      start_op(1'($urandom_range(0, 1)), rnd128(), rnd128(), rnd128(), rnd128(), 1'b1, 1'b0, e);
      wait_ready();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 128'(sb_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
